// File: rtl/riscv_loader_pkg.sv
// Shared types and widths for the riscv external-memory bring-up loader.
package riscv_loader_pkg;

  localparam int MEM_ADDR_W  = 9;
  localparam int WORD_W      = 32;
  localparam int DEBUG_SEL_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_CORE_RST,
    ST_RUN,
    ST_DONE
  } loader_state_t;

  // Order in which host words fill one load slot.
  typedef enum logic [1:0] {
    W_INST1,
    W_INST2,
    W_DATA1,
    W_DATA2
  } word_idx_t;

endpackage

// File: rtl/debug_probe.sv
// Debug-register read: latches the select, waits DBG_LAT cycles, then captures
// the core's debug output and pulses valid for one cycle.
module debug_probe
  import riscv_loader_pkg::*;
#(
  parameter int DBG_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   req,
  input  logic [DEBUG_SEL_W-1:0] sel,
  input  logic [WORD_W-1:0]      debug_output,
  output logic [DEBUG_SEL_W-1:0] debug_sel,
  output logic                   valid,
  output logic [WORD_W-1:0]      data
);

  localparam int LAT_W = (DBG_LAT > 1) ? $clog2(DBG_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DBG_LAT - 1);

  logic             pending;
  logic [LAT_W-1:0] lat_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      debug_sel <= '0;
      valid     <= 1'b0;
      data      <= '0;
      pending   <= 1'b0;
      lat_cnt   <= '0;
    end else if (abort) begin
      // Drop any in-flight read; the select keeps its last value.
      valid   <= 1'b0;
      pending <= 1'b0;
      lat_cnt <= '0;
    end else begin
      valid <= 1'b0;
      if (pending) begin
        if (lat_cnt == LAT_LAST) begin
          data    <= debug_output;
          valid   <= 1'b1;
          pending <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end else if (enable && req) begin
        debug_sel <= sel;
        pending   <= 1'b1;
        lat_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/ex_mem_loader.sv
// Bring-up controller: streams host words into the core's instruction/data
// memories, then sequences core reset release, a bounded run and debug reads.
module ex_mem_loader
  import riscv_loader_pkg::*;
#(
  parameter int ADDR_STEP  = 2,
  parameter int RST_CYCLES = 2,
  parameter int DBG_LAT    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_slots,
  input  logic [CNT_W-1:0]       run_cycles,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   halt_req,
  input  logic                   dbg_req,
  input  logic [DEBUG_SEL_W-1:0] dbg_sel,
  output logic                   dbg_valid,
  output logic [WORD_W-1:0]      dbg_data,
  output logic                   busy,
  output logic                   done,
  output logic                   core_reset,
  output logic                   enable_load_ex_mem,
  output logic                   enable_halt,
  output logic [MEM_ADDR_W-1:0]  InstExMemAddress,
  output logic [MEM_ADDR_W-1:0]  DataExMemAddress,
  output logic [WORD_W-1:0]      InstExMemData1,
  output logic [WORD_W-1:0]      InstExMemData2,
  output logic [WORD_W-1:0]      DataExMemData1,
  output logic [WORD_W-1:0]      DataExMemData2,
  output logic [DEBUG_SEL_W-1:0] DebugSel,
  input  logic [WORD_W-1:0]      DebugOutput
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  // Host stream handshake: a word transfers on a rising edge where
  // wr_valid and wr_ready are both high; wr_data must hold while wr_valid
  // is high and unaccepted.
  loader_state_t       state;
  word_idx_t           word_idx;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    run_q;
  logic [CNT_W-1:0]    slot_cnt;
  logic [CNT_W-1:0]    slot_next;
  logic [CNT_W-1:0]    run_cnt;
  logic [CNT_W-1:0]    run_next;
  logic [RST_W-1:0]    rst_cnt;
  logic [MEM_ADDR_W-1:0] slot_addr;
  logic                handshake;
  logic                dbg_enable;

  assign handshake  = wr_valid & wr_ready;
  assign slot_next  = slot_cnt + 1'b1;
  assign run_next   = run_cnt + 1'b1;
  assign slot_addr  = MEM_ADDR_W'(32'(slot_cnt) * 32'(ADDR_STEP));
  assign dbg_enable = (state == ST_RUN) || (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      word_idx           <= W_INST1;
      core_reset         <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      wr_ready           <= 1'b0;
      enable_load_ex_mem <= 1'b0;
      enable_halt        <= 1'b0;
      InstExMemAddress   <= '0;
      DataExMemAddress   <= '0;
      InstExMemData1     <= '0;
      InstExMemData2     <= '0;
      DataExMemData1     <= '0;
      DataExMemData2     <= '0;
      num_q              <= '0;
      run_q              <= '0;
      slot_cnt           <= '0;
      run_cnt            <= '0;
      rst_cnt            <= '0;
    end else if (abort) begin
      state              <= ST_IDLE;
      core_reset         <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      wr_ready           <= 1'b0;
      enable_load_ex_mem <= 1'b0;
      enable_halt        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q       <= num_slots;
            run_q       <= run_cycles;
            core_reset  <= 1'b1;
            done        <= 1'b0;
            enable_halt <= 1'b0;
            busy        <= 1'b1;
            slot_cnt    <= '0;
            rst_cnt     <= '0;
            word_idx    <= W_INST1;
            if (num_slots == '0) begin
              state <= ST_CORE_RST;
            end else begin
              state    <= ST_COLLECT;
              wr_ready <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (handshake) begin
            case (word_idx)
              W_INST1: InstExMemData1 <= wr_data;
              W_INST2: InstExMemData2 <= wr_data;
              W_DATA1: DataExMemData1 <= wr_data;
              default: DataExMemData2 <= wr_data;
            endcase
            word_idx <= word_idx_t'(word_idx + 2'd1);
            // Ready drops with the 4th word so nothing is over-accepted.
            if (word_idx == W_DATA2) begin
              wr_ready           <= 1'b0;
              enable_load_ex_mem <= 1'b1;
              InstExMemAddress   <= slot_addr;
              DataExMemAddress   <= slot_addr;
              state              <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          enable_load_ex_mem <= 1'b0;
          slot_cnt           <= slot_next;
          word_idx           <= W_INST1;
          if (slot_next == num_q) begin
            state   <= ST_CORE_RST;
            rst_cnt <= '0;
          end else begin
            state    <= ST_COLLECT;
            wr_ready <= 1'b1;
          end
        end
        ST_CORE_RST: begin
          if (rst_cnt == RST_LAST) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            run_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          enable_halt <= halt_req;
          // Only unhalted cycles count toward the run budget; 0 = unlimited.
          if (!enable_halt) begin
            run_cnt <= run_next;
            if ((run_q != '0) && (run_next == run_q)) begin
              state       <= ST_DONE;
              enable_halt <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  debug_probe #(
    .DBG_LAT (DBG_LAT)
  ) u_debug_probe (
    .clk          (clk),
    .reset        (reset),
    .enable       (dbg_enable),
    .abort        (abort),
    .req          (dbg_req),
    .sel          (dbg_sel),
    .debug_output (DebugOutput),
    .debug_sel    (DebugSel),
    .valid        (dbg_valid),
    .data         (dbg_data)
  );

endmodule

// File: tb/tb_ex_mem_loader.sv
// Self-checking bench for ex_mem_loader: randomized word streams, halts and
// debug reads checked against a slot/word/cycle reference model.
module tb_ex_mem_loader;
  import riscv_loader_pkg::*;

  localparam int ADDR_STEP  = 2;
  localparam int RST_CYCLES = 2;
  localparam int DBG_LAT    = 1;
  localparam int CNT_W      = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  num_slots = '0;
  logic [CNT_W-1:0]  run_cycles = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [31:0]       wr_data = '0;
  logic              halt_req = 1'b0;
  logic              dbg_req = 1'b0;
  logic [4:0]        dbg_sel = '0;
  logic              dbg_valid;
  logic [31:0]       dbg_data;
  logic              busy, done, core_reset, enable_load_ex_mem, enable_halt;
  logic [8:0]        InstExMemAddress, DataExMemAddress;
  logic [31:0]       InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2;
  logic [4:0]        DebugSel;
  logic [31:0]       DebugOutput;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] dbg_regs[32];

  // Core model: the debug register file answers the current select.
  assign DebugOutput = dbg_regs[DebugSel];

  ex_mem_loader #(
    .ADDR_STEP(ADDR_STEP), .RST_CYCLES(RST_CYCLES), .DBG_LAT(DBG_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_slots(num_slots), .run_cycles(run_cycles),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .halt_req(halt_req), .dbg_req(dbg_req), .dbg_sel(dbg_sel),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data),
    .busy(busy), .done(done), .core_reset(core_reset),
    .enable_load_ex_mem(enable_load_ex_mem), .enable_halt(enable_halt),
    .InstExMemAddress(InstExMemAddress), .DataExMemAddress(DataExMemAddress),
    .InstExMemData1(InstExMemData1), .InstExMemData2(InstExMemData2),
    .DataExMemData1(DataExMemData1), .DataExMemData2(DataExMemData2),
    .DebugSel(DebugSel), .DebugOutput(DebugOutput)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_start(input int ns, input int rc);
    num_slots = CNT_W'(ns);
    run_cycles = CNT_W'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (core_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || wr_ready !== logic'(ns != 0)) begin
      bad++;
      $display("FAIL start_entry got core_reset=%b done=%b busy=%b wr_ready=%b want 1 0 1 %0d",
               core_reset, done, busy, wr_ready, ns != 0);
    end
  endtask

  // Streams 4*ns words with random gaps and checks every memory write.
  task automatic load_slots(input int ns, input int gap);
    int slot = 0;
    int hs = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] e0, e1, e2, e3;
    logic [8:0] ea;
    exp_q.delete();
    while (slot < ns && cyc < 40 * ns + 50) begin
      cyc++;
      if (enable_load_ex_mem === 1'b1) begin
        ea = 9'((slot * ADDR_STEP) % 512);
        total++;
        if (exp_q.size() != 4) begin
          bad++;
          $display("FAIL write_word_count slot=%0d got=%0d want=4", slot, exp_q.size());
        end else begin
          e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
          e2 = exp_q.pop_front(); e3 = exp_q.pop_front();
          total++;
          if ({InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2} !== {e0, e1, e2, e3}) begin
            bad++;
            $display("FAIL write_data slot=%0d got=%h_%h_%h_%h want=%h_%h_%h_%h", slot,
                     InstExMemData1, InstExMemData2, DataExMemData1, DataExMemData2, e0, e1, e2, e3);
          end
        end
        total++;
        if (InstExMemAddress !== ea || DataExMemAddress !== ea || wr_ready !== 1'b0) begin
          bad++;
          $display("FAIL write_addr slot=%0d got inst=%0d data=%0d ready=%b want=%0d ready=0",
                   slot, InstExMemAddress, DataExMemAddress, wr_ready, ea);
        end
        exp_q.delete();
        slot++;
      end
      if (slot == ns) begin
        wr_valid = 1'b0;
        break;
      end
      if (!hold) begin
        if (hs < 4 * ns && $urandom_range(0, 99) >= gap) begin
          wr_valid = 1'b1;
          if (src_q.size() > 0) wr_data = src_q.pop_front();
          else wr_data = $urandom();
        end else begin
          wr_valid = 1'b0;
        end
      end
      if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
        exp_q.push_back(wr_data);
        hs++;
        hold = 1'b0;
      end else begin
        hold = wr_valid;
      end
      @(negedge clk);
    end
    total++;
    if (slot != ns || hs != 4 * ns) begin
      bad++;
      $display("FAIL load_progress got slots=%0d handshakes=%0d want slots=%0d handshakes=%0d",
               slot, hs, ns, 4 * ns);
    end
  endtask

  task automatic check_core_rst();
    int n = 0;
    while (core_reset === 1'b1 && n < 20) begin
      total++;
      if (enable_load_ex_mem !== 1'b0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL core_rst_outputs cyc=%0d got load=%b ready=%b busy=%b want 0 0 1",
                 n, enable_load_ex_mem, wr_ready, busy);
      end
      n++;
      @(negedge clk);
    end
    total++;
    if (n != RST_CYCLES) begin
      bad++;
      $display("FAIL core_reset_len got=%0d want=%0d", n, RST_CYCLES);
    end
  endtask

  // halt_req is high during run cycles [h_start, h_start+h_len).
  task automatic run_phase(input int rc, input int h_start, input int h_len);
    int cnt = 0;
    logic eh_model = 1'b0;
    for (int k = 0; k < rc + h_len + 20; k++) begin
      total++;
      if (done !== 1'b0 || core_reset !== 1'b0 || enable_halt !== eh_model || wr_ready !== 1'b0) begin
        bad++;
        $display("FAIL run_cycle k=%0d got done=%b core_reset=%b halt=%b ready=%b want 0 0 %b 0",
                 k, done, core_reset, enable_halt, wr_ready, eh_model);
      end
      if (!eh_model) cnt++;
      halt_req = (k >= h_start && k < h_start + h_len);
      eh_model = halt_req;
      @(negedge clk);
      if (cnt == rc) break;
    end
    halt_req = 1'b0;
    total++;
    if (done !== 1'b1 || enable_halt !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_state got done=%b halt=%b core_reset=%b busy=%b want 1 1 0 0",
               done, enable_halt, core_reset, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (core_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0 ||
        enable_load_ex_mem !== 1'b0 || enable_halt !== 1'b0 || dbg_valid !== 1'b0 ||
        InstExMemAddress !== 9'd0 || DataExMemAddress !== 9'd0 || DebugSel !== 5'd0 ||
        dbg_data !== 32'd0 || InstExMemData1 !== 32'd0 || DataExMemData2 !== 32'd0) begin
      bad++;
      $display("FAIL reset_values got core_reset=%b busy=%b ready=%b load=%b halt=%b dsel=%0d",
               core_reset, busy, wr_ready, enable_load_ex_mem, enable_halt, DebugSel);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_slot();
    src_q = '{32'h00100393, 32'h00038303, 32'h00008F00, 32'h000000FF};
    do_start(1, 5);
    load_slots(1, 0);
    @(negedge clk);
    check_core_rst();
    run_phase(5, 0, 0);
  endtask

  task automatic test_multi_slot_gaps();
    do_start(3, 3);
    load_slots(3, 45);
    wr_valid = 1'b1;
    @(negedge clk);
    check_core_rst();
    wr_valid = 1'b0;
    run_phase(3, 0, 0);
  endtask

  task automatic test_halt();
    do_start(1, 10);
    load_slots(1, 20);
    @(negedge clk);
    check_core_rst();
    run_phase(10, 4, 2);
  endtask

  task automatic test_zero_slots();
    do_start(0, 3);
    check_core_rst();
    run_phase(3, 0, 0);
  endtask

  task automatic test_debug();
    logic [4:0] s, n;
    logic [31:0] v;
    do_start(0, 0);
    check_core_rst();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        s = 5'd26; v = 32'h000000FF;
      end else begin
        s = 5'($urandom_range(0, 31)); v = $urandom();
      end
      n = s ^ 5'h1f;
      dbg_regs[s] = v;
      dbg_regs[n] = ~v;
      dbg_req = 1'b1;
      dbg_sel = s;
      @(negedge clk);
      total++;
      if (DebugSel !== s || dbg_valid !== 1'b0) begin
        bad++;
        $display("FAIL debug_sel i=%0d got sel=%0d valid=%b want sel=%0d valid=0", i, DebugSel, dbg_valid, s);
      end
      for (int j = 0; j < DBG_LAT; j++) begin
        dbg_sel = n;
        if (j > 0) begin
          total++;
          if (dbg_valid !== 1'b0) begin
            bad++;
            $display("FAIL debug_early i=%0d got valid=%b want 0", i, dbg_valid);
          end
        end
        @(negedge clk);
      end
      dbg_req = 1'b0;
      total++;
      if (dbg_valid !== 1'b1 || dbg_data !== v || DebugSel !== s) begin
        bad++;
        $display("FAIL debug_capture i=%0d got valid=%b data=%h sel=%0d want 1 %h %0d",
                 i, dbg_valid, dbg_data, DebugSel, v, s);
      end
      @(negedge clk);
      total++;
      if (dbg_valid !== 1'b0) begin
        bad++;
        $display("FAIL debug_pulse_len i=%0d got valid=%b want 0", i, dbg_valid);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_abort_debug();
    logic [4:0] s;
    s = 5'($urandom_range(0, 31));
    dbg_regs[s] = $urandom();
    dbg_req = 1'b1;
    dbg_sel = s;
    @(negedge clk);
    dbg_req = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || core_reset !== 1'b1 || enable_halt !== 1'b0 || dbg_valid !== 1'b0 ||
        wr_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state got busy=%b core_reset=%b halt=%b valid=%b ready=%b want 0 1 0 0 0",
               busy, core_reset, enable_halt, dbg_valid, wr_ready);
    end
    dbg_req = 1'b1;
    dbg_sel = ~s;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (dbg_valid !== 1'b0 || DebugSel !== s) begin
        bad++;
        $display("FAIL abort_no_debug got valid=%b sel=%0d want 0 %0d", dbg_valid, DebugSel, s);
      end
    end
    dbg_req = 1'b0;
  endtask

  task automatic test_start_abort();
    do_start(0, 2);
    check_core_rst();
    run_phase(2, 0, 0);
    num_slots = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      total++;
      if (busy !== 1'b0 || core_reset !== 1'b1 || wr_ready !== 1'b0 || done !== 1'b0 || enable_halt !== 1'b0) begin
        bad++;
        $display("FAIL start_abort got busy=%b core_reset=%b ready=%b done=%b halt=%b want 0 1 0 0 0",
                 busy, core_reset, wr_ready, done, enable_halt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_collect();
    do_start(2, 0);
    wr_valid = 1'b1;
    wr_data = 32'hA5A5_0001;
    @(negedge clk);
    wr_data = 32'hA5A5_0002;
    @(negedge clk);
    wr_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (core_reset !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0 || InstExMemData1 !== 32'd0 ||
        InstExMemData2 !== 32'd0 || enable_load_ex_mem !== 1'b0 || DebugSel !== 5'd0 || dbg_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_collect got core_reset=%b busy=%b ready=%b d1=%h d2=%h want 1 0 0 0 0",
               core_reset, busy, wr_ready, InstExMemData1, InstExMemData2);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset got ready=%b busy=%b want 0 0", wr_ready, busy);
      end
    end
  endtask

  task automatic test_addr_wrap();
    do_start(258, 1);
    load_slots(258, 10);
    @(negedge clk);
    check_core_rst();
    run_phase(1, 0, 0);
  endtask

  task automatic test_random();
    int ns, rc, hs, hl;
    for (int it = 0; it < 4; it++) begin
      ns = $urandom_range(1, 5);
      rc = $urandom_range(1, 8);
      hs = $urandom_range(0, rc - 1);
      hl = $urandom_range(0, 3);
      do_start(ns, rc);
      load_slots(ns, $urandom_range(0, 50));
      @(negedge clk);
      check_core_rst();
      run_phase(rc, hs, hl);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dbg_regs[i] = 32'(i) * 32'h0101_0101;
    test_reset();
    test_single_slot();
    test_multi_slot_gaps();
    test_halt();
    test_zero_slots();
    test_debug();
    test_abort_debug();
    test_start_abort();
    test_reset_mid_collect();
    test_addr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
